subtractors_array_seq: RTL and testbench
========================================

Name: subtractors_array_seq

Overview:
- Sequential, lane-parallel successor of the combinational exponent subtractor array in the log-domain divider/softmax datapath.
- Captures a bus of NUM_INPUTS mantissa-domain values plus one exp_sum. Streams x[i] - exp_sum out LANES results per beat under a valid/ready handshake.
- Sits between the exponent-sum accumulator and the downstream exponent/normaliser stage. Lets a narrow consumer apply backpressure.

Parameters:
- NUM_INPUTS, 10, number of elements per vector.
- EXP_WIDTH, 9, width of exp_sum and of each result.
- MANT_WIDTH, 8, width of each input element; must be <= EXP_WIDTH.
- LANES, 2, results produced per output beat; 1 <= LANES <= NUM_INPUTS.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  synchronous active-high reset.
- in_valid  in  1  input vector and exp_sum valid.
- in_ready  out  1  block can accept a vector.
- exp_sum  in  EXP_WIDTH  value subtracted from every element.
- input_bus  in  NUM_INPUTS*MANT_WIDTH  element i at bits [i*MANT_WIDTH +: MANT_WIDTH].
- out_valid  out  1  output beat valid.
- out_ready  in  1  consumer accepts beat.
- exp_out  out  LANES*EXP_WIDTH  lane k at bits [k*EXP_WIDTH +: EXP_WIDTH]; holds element beat*LANES+k.
- lane_mask  out  LANES  bit k set when lane k holds a real element.
- out_index  out  clog2(BEATS) (min 1)  beat number, 0-based.
- out_last  out  1  final beat of the vector.
- busy  out  1  vector held, not yet fully drained.

Behaviour:
- Interface: one clock; reset is synchronous and active-high. Clock port is clk, reset port is rst.
- BEATS = ceil(NUM_INPUTS/LANES).
- Reset: state IDLE, in_ready=1, out_valid=0, busy=0, out_last=0, out_index=0, lane_mask=0, exp_out=0. Internal capture registers are cleared.
- FSM IDLE:
  - in_ready=1.
  - If in_valid, capture input_bus and exp_sum into registers, set beat=0, go to RUN.
- FSM RUN:
  - in_ready=0, busy=1, out_valid=1.
  - A beat transfers when out_valid && out_ready.
  - On a transfer with beat < BEATS-1: beat increments.
  - On a transfer with beat = BEATS-1: go to IDLE, out_valid drops next cycle.
  - There is no back-to-back overlap. The next vector is accepted no earlier than the cycle after the last beat transfers.
- Latency: vector accepted on edge N gives out_valid=1 with beat 0 after edge N. Minimum BEATS+1 cycles per vector with out_ready held high.
- Output stability: exp_out, lane_mask, out_index and out_last are registered. They are held constant while out_valid && !out_ready.
- Arithmetic, per lane:
  - Element x is zero-extended from MANT_WIDTH to EXP_WIDTH.
  - Result = (x - exp_sum) mod 2^EXP_WIDTH, i.e. a two's-complement wrap, bit-identical to the previous combinational array.
- Partial last beat: lanes with beat*LANES+k >= NUM_INPUTS output 0 and have their lane_mask bit clear. All other beats have an all-ones mask.
- out_last = (beat == BEATS-1) while out_valid. Both out_last and out_index are 0 when idle.
- in_valid in RUN is ignored; the held vector is not disturbed.
- Reset mid-vector: the remaining beats are discarded. Next cycle is IDLE with all outputs at reset values.
- Reset takes priority over a simultaneous handshake.

Optional Feature:
- Macro: SUBARRAY_SAT_EN.
- Defined: the difference is computed exactly in EXP_WIDTH+1 bits, signed. The result is interpreted as signed EXP_WIDTH and clamped to [-2^(EXP_WIDTH-1), 2^(EXP_WIDTH-1)-1]. Add output sat_flag (width LANES), set per real lane when clamping occurred; it is registered and held with exp_out.
- Undefined: modulo wrap as above; no sat_flag port.

Test Plan:
- Defaults (N=10, L=2). x[i]=10*i, exp_sum=20, out_ready=1 -> 5 beats, index 0..4. Beat0 = {9'h1EC, 9'h1F6}, beat1 = {9'h000, 9'h00A}, beat4 = {9'h03C, 9'h046}. out_last only on beat4, mask 2'b11 throughout, in_ready=1 the cycle after.
- Same vector, out_ready low for 3 cycles on beat 2 -> exp_out = {9'h014, 9'h01E} and out_index=2 held steady; no beat skipped or repeated.
- LANES=3, N=10, x[i]=i, exp_sum=0 -> 4 beats; beat3 lane0 = 9, lanes1-2 = 0, lane_mask = 3'b001, out_last=1.
- Assert rst during beat 1 -> next cycle out_valid=0, busy=0, in_ready=1. New vector x[i]=255, exp_sum=0 -> all results 9'h0FF.
- Wrap vs saturation: x[0]=0, exp_sum=300 -> 9'h0D4 without SUBARRAY_SAT_EN; 9'h100 with sat_flag[0]=1 when defined. x[0]=255, exp_sum=0 -> 9'h0FF in both builds, sat_flag=0.
- in_valid held high during RUN with different data -> output stream unaffected; second vector captured only when in_ready=1.

Source files
------------

// File: rtl/subtractors_array_seq.sv
// Lane-parallel exponent subtractor: captures a vector and streams x[i]-exp_sum.
// Optional SUBARRAY_SAT_EN clamps to signed range and adds the sat_flag port.
module subtractors_array_seq #(
    parameter int NUM_INPUTS = 10,
    parameter int EXP_WIDTH  = 9,
    parameter int MANT_WIDTH = 8,
    parameter int LANES      = 2,
    localparam int BEATS     = (NUM_INPUTS + LANES - 1) / LANES,
    localparam int IDX_W     = (BEATS > 1) ? $clog2(BEATS) : 1
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             in_valid,
    output logic                             in_ready,
    input  logic [EXP_WIDTH-1:0]             exp_sum,
    input  logic [NUM_INPUTS*MANT_WIDTH-1:0] input_bus,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic [LANES*EXP_WIDTH-1:0]       exp_out,
    output logic [LANES-1:0]                 lane_mask,
    output logic [IDX_W-1:0]                 out_index,
    output logic                             out_last,
    output logic                             busy
`ifdef SUBARRAY_SAT_EN
    ,
    output logic [LANES-1:0]                 sat_flag
`endif
);

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    localparam logic [IDX_W-1:0] LAST_BEAT = IDX_W'(BEATS - 1);

    state_t state_q;
    state_t state_d;

    logic [NUM_INPUTS*MANT_WIDTH-1:0] x_q;
    logic [EXP_WIDTH-1:0]             exp_q;

    logic capture;
    logic advance;
    logic finish;

    logic [NUM_INPUTS*MANT_WIDTH-1:0] src_bus;
    logic [EXP_WIDTH-1:0]             src_exp;
    logic [IDX_W-1:0]                 nb;

    logic [LANES*EXP_WIDTH-1:0] res_d;
    logic [LANES-1:0]           mask_d;
`ifdef SUBARRAY_SAT_EN
    logic [LANES-1:0]           sat_d;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        capture   = 1'b0;
        advance   = 1'b0;
        finish    = 1'b0;
        unique case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    capture = 1'b1;
                    state_d = RUN;
                end
            end
            RUN: begin
                out_valid = 1'b1;
                busy      = 1'b1;
                if (out_ready) begin
                    if (out_index == LAST_BEAT) begin
                        finish  = 1'b1;
                        state_d = IDLE;
                    end else begin
                        advance = 1'b1;
                    end
                end
            end
        endcase
    end

    // Beat 0 is computed straight from the input bus so it is valid right after capture.
    always_comb begin
        src_bus = capture ? input_bus : x_q;
        src_exp = capture ? exp_sum : exp_q;
        nb      = capture ? '0 : out_index + 1'b1;
    end

    always_comb begin
        int idx;
        logic [EXP_WIDTH-1:0] x_ext;
`ifdef SUBARRAY_SAT_EN
        logic [EXP_WIDTH:0] diff;
        diff  = '0;
        sat_d = '0;
`endif
        idx    = 0;
        x_ext  = '0;
        res_d  = '0;
        mask_d = '0;
        for (int k = 0; k < LANES; k++) begin
            idx   = int'(nb) * LANES + k;
            x_ext = '0;
            if (idx < NUM_INPUTS) begin
                x_ext     = EXP_WIDTH'(src_bus[idx*MANT_WIDTH +: MANT_WIDTH]);
                mask_d[k] = 1'b1;
`ifdef SUBARRAY_SAT_EN
                // Top two bits disagree when the exact difference leaves signed range.
                diff = {1'b0, x_ext} - {1'b0, src_exp};
                if (diff[EXP_WIDTH] != diff[EXP_WIDTH-1]) begin
                    sat_d[k] = 1'b1;
                    res_d[k*EXP_WIDTH +: EXP_WIDTH] = diff[EXP_WIDTH]
                        ? {1'b1, {(EXP_WIDTH-1){1'b0}}}
                        : {1'b0, {(EXP_WIDTH-1){1'b1}}};
                end else begin
                    res_d[k*EXP_WIDTH +: EXP_WIDTH] = diff[EXP_WIDTH-1:0];
                end
`else
                res_d[k*EXP_WIDTH +: EXP_WIDTH] = x_ext - src_exp;
`endif
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            x_q       <= '0;
            exp_q     <= '0;
            exp_out   <= '0;
            lane_mask <= '0;
            out_index <= '0;
            out_last  <= 1'b0;
`ifdef SUBARRAY_SAT_EN
            sat_flag  <= '0;
`endif
        end else if (capture || advance) begin
            if (capture) begin
                x_q   <= input_bus;
                exp_q <= exp_sum;
            end
            exp_out   <= res_d;
            lane_mask <= mask_d;
            out_index <= nb;
            out_last  <= (nb == LAST_BEAT);
`ifdef SUBARRAY_SAT_EN
            sat_flag  <= sat_d;
`endif
        end else if (finish) begin
            exp_out   <= '0;
            lane_mask <= '0;
            out_index <= '0;
            out_last  <= 1'b0;
`ifdef SUBARRAY_SAT_EN
            sat_flag  <= '0;
`endif
        end
    end

endmodule

// File: tb/tb_subtractors_array_seq.sv
// Bench for subtractors_array_seq: LANES=2 and LANES=3 instances vs a
// behavioural model of x[i]-exp_sum per element.
module tb_subtractors_array_seq;

    localparam int N  = 10;
    localparam int EW = 9;
    localparam int MW = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic          in_valid0;
    logic          in_valid3;
    logic          out_ready;
    logic [EW-1:0] exp_sum;
    logic [N*MW-1:0] input_bus;

    logic          in_ready0, out_valid0, out_last0, busy0;
    logic [2*EW-1:0] exp_out0;
    logic [1:0]    lane_mask0;
    logic [2:0]    out_index0;

    logic          in_ready3, out_valid3, out_last3, busy3;
    logic [3*EW-1:0] exp_out3;
    logic [2:0]    lane_mask3;
    logic [1:0]    out_index3;
`ifdef SUBARRAY_SAT_EN
    logic [1:0]    sat_flag0;
    logic [2:0]    sat_flag3;
`endif

    subtractors_array_seq #(
        .NUM_INPUTS(N), .EXP_WIDTH(EW), .MANT_WIDTH(MW), .LANES(2)
    ) u_dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid0), .in_ready(in_ready0),
        .exp_sum(exp_sum), .input_bus(input_bus),
        .out_valid(out_valid0), .out_ready(out_ready),
        .exp_out(exp_out0), .lane_mask(lane_mask0),
        .out_index(out_index0), .out_last(out_last0),
        .busy(busy0)
`ifdef SUBARRAY_SAT_EN
        , .sat_flag(sat_flag0)
`endif
    );

    subtractors_array_seq #(
        .NUM_INPUTS(N), .EXP_WIDTH(EW), .MANT_WIDTH(MW), .LANES(3)
    ) u_dut3 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid3), .in_ready(in_ready3),
        .exp_sum(exp_sum), .input_bus(input_bus),
        .out_valid(out_valid3), .out_ready(out_ready),
        .exp_out(exp_out3), .lane_mask(lane_mask3),
        .out_index(out_index3), .out_last(out_last3),
        .busy(busy3)
`ifdef SUBARRAY_SAT_EN
        , .sat_flag(sat_flag3)
`endif
    );

    int sel;
    logic s_valid, s_ready, s_last, s_busy;
    logic [63:0] s_eo;
    int s_idx;
    logic [7:0] s_mask, s_sat;

    always_comb begin
        s_valid = 1'b0;
        s_ready = 1'b0;
        s_last  = 1'b0;
        s_busy  = 1'b0;
        s_eo    = '0;
        s_idx   = 0;
        s_mask  = '0;
        s_sat   = '0;
        if (sel == 0) begin
            s_valid = out_valid0;
            s_ready = in_ready0;
            s_last  = out_last0;
            s_busy  = busy0;
            s_eo    = 64'(exp_out0);
            s_idx   = int'(out_index0);
            s_mask  = 8'(lane_mask0);
`ifdef SUBARRAY_SAT_EN
            s_sat   = 8'(sat_flag0);
`endif
        end else begin
            s_valid = out_valid3;
            s_ready = in_ready3;
            s_last  = out_last3;
            s_busy  = busy3;
            s_eo    = 64'(exp_out3);
            s_idx   = int'(out_index3);
            s_mask  = 8'(lane_mask3);
`ifdef SUBARRAY_SAT_EN
            s_sat   = 8'(sat_flag3);
`endif
        end
    end

    int tests = 0;
    int fails = 0;
    int cur_x[N];
    int cur_e;

    typedef struct {
        int         x;
        int         e;
        logic [8:0] want_wrap;
        logic [8:0] want_sat;
        logic       flag;
    } vec_t;
    vec_t tbl[9];

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] want);
        tests++;
        if (act !== want) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, want);
        end
    endtask

    // Exact integer difference, then wrapped or clamped into 9 bits.
    function automatic int ref_lane(int x, int e);
        int d;
        d = x - e;
`ifdef SUBARRAY_SAT_EN
        if (d > 255) d = 255;
        if (d < -256) d = -256;
`endif
        return d & 511;
    endfunction

    function automatic logic [63:0] ref_word(int b, int l);
        logic [63:0] w;
        w = '0;
        for (int k = 0; k < l; k++) begin
            if (b * l + k < N)
                w |= 64'(ref_lane(cur_x[b*l+k], cur_e)) << (k * EW);
        end
        return w;
    endfunction

    function automatic logic [7:0] ref_mask(int b, int l);
        logic [7:0] m;
        m = '0;
        for (int k = 0; k < l; k++)
            if (b * l + k < N) m[k] = 1'b1;
        return m;
    endfunction

    function automatic logic [7:0] ref_sat(int b, int l);
        logic [7:0] m;
        int d;
        m = '0;
        for (int k = 0; k < l; k++) begin
            if (b * l + k < N) begin
                d = cur_x[b*l+k] - cur_e;
                if (d > 255 || d < -256) m[k] = 1'b1;
            end
        end
        return m;
    endfunction

    task automatic pack();
        for (int i = 0; i < N; i++)
            input_bus[i*MW +: MW] = MW'(cur_x[i]);
        exp_sum = EW'(cur_e);
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_valid"}, 64'(s_valid), 64'(0));
        check({tag, "_ready"}, 64'(s_ready), 64'(1));
        check({tag, "_busy"}, 64'(s_busy), 64'(0));
        check({tag, "_index"}, 64'(s_idx), 64'(0));
        check({tag, "_last"}, 64'(s_last), 64'(0));
        check({tag, "_mask"}, 64'(s_mask), 64'(0));
        check({tag, "_data"}, s_eo, 64'(0));
    endtask

    task automatic send(input int which, input bit hold);
        int n;
        sel = which;
        n = 0;
        while (!s_ready && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("send_in_ready", 64'(s_ready), 64'(1));
        pack();
        if (which == 0) in_valid0 = 1'b1;
        else in_valid3 = 1'b1;
        @(posedge clk);
        #1;
        if (!hold) in_valid0 = 1'b0;
        in_valid3 = 1'b0;
    endtask

    task automatic drain(input int which, input int stall_beat,
                         input int stall_n, input bit rnd);
        int l, beats, b, cyc, stall_left;
        sel = which;
        l = (which == 0) ? 2 : 3;
        beats = (N + l - 1) / l;
        b = 0;
        cyc = 0;
        stall_left = stall_n;
        while (b < beats) begin
            if (cyc > 400) begin
                tests++;
                fails++;
                $display("FAIL drain_timeout: stuck at beat %0d expected %0d beats", b, beats);
                break;
            end
            check("beat_valid", 64'(s_valid), 64'(1));
            check("beat_busy", 64'(s_busy), 64'(1));
            check("beat_in_ready", 64'(s_ready), 64'(0));
            check("beat_index", 64'(s_idx), 64'(b));
            check("beat_last", 64'(s_last), 64'(b == beats - 1));
            check("beat_mask", 64'(s_mask), 64'(ref_mask(b, l)));
            check("beat_data", s_eo, ref_word(b, l));
`ifdef SUBARRAY_SAT_EN
            check("beat_sat", 64'(s_sat), 64'(ref_sat(b, l)));
`endif
            if (b == stall_beat && stall_left > 0) begin
                out_ready = 1'b0;
                stall_left--;
            end else if (rnd) begin
                out_ready = ($urandom_range(0, 2) != 0);
            end else begin
                out_ready = 1'b1;
            end
            @(posedge clk);
            #1;
            cyc++;
            if (out_ready) b++;
        end
        out_ready = 1'b1;
        check_idle("drained");
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        in_valid0 = 1'b0;
        in_valid3 = 1'b0;
        out_ready = 1'b1;
        input_bus = '0;
        exp_sum   = '0;
        sel       = 0;

        tbl[0] = '{x: 0,   e: 300, want_wrap: 9'h0D4, want_sat: 9'h100, flag: 1'b1};
        tbl[1] = '{x: 255, e: 0,   want_wrap: 9'h0FF, want_sat: 9'h0FF, flag: 1'b0};
        tbl[2] = '{x: 10,  e: 20,  want_wrap: 9'h1F6, want_sat: 9'h1F6, flag: 1'b0};
        tbl[3] = '{x: 0,   e: 0,   want_wrap: 9'h000, want_sat: 9'h000, flag: 1'b0};
        tbl[4] = '{x: 255, e: 511, want_wrap: 9'h100, want_sat: 9'h100, flag: 1'b0};
        tbl[5] = '{x: 0,   e: 511, want_wrap: 9'h001, want_sat: 9'h100, flag: 1'b1};
        tbl[6] = '{x: 100, e: 50,  want_wrap: 9'h032, want_sat: 9'h032, flag: 1'b0};
        tbl[7] = '{x: 200, e: 456, want_wrap: 9'h100, want_sat: 9'h100, flag: 1'b0};
        tbl[8] = '{x: 199, e: 456, want_wrap: 9'h0FF, want_sat: 9'h100, flag: 1'b1};

        repeat (3) @(posedge clk);
        #1;
        sel = 0;
        check_idle("reset2");
        sel = 1;
        check_idle("reset3");
        rst = 1'b0;
        @(posedge clk);
        #1;

        for (int i = 0; i < N; i++) cur_x[i] = 10 * i;
        cur_e = 20;
        send(0, 1'b0);
        check("plan_beat0", s_eo, {46'd0, 9'h1F6, 9'h1EC});
        drain(0, -1, 0, 1'b0);

        send(0, 1'b0);
        drain(0, 2, 3, 1'b0);

        for (int i = 0; i < N; i++) cur_x[i] = i;
        cur_e = 0;
        send(1, 1'b0);
        drain(1, -1, 0, 1'b0);

        for (int i = 0; i < N; i++) cur_x[i] = 10 * i;
        cur_e = 20;
        send(0, 1'b0);
        @(posedge clk);
        #1;
        check("rst_pre_index", 64'(s_idx), 64'(1));
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check_idle("midrst");
        for (int i = 0; i < N; i++) cur_x[i] = 255;
        cur_e = 0;
        send(0, 1'b0);
        drain(0, -1, 0, 1'b0);

        for (int t = 0; t < 9; t++) begin
            for (int i = 0; i < N; i++) cur_x[i] = tbl[t].x;
            cur_e = tbl[t].e;
            send(0, 1'b0);
`ifdef SUBARRAY_SAT_EN
            check("tbl_value", 64'(s_eo[8:0]), 64'(tbl[t].want_sat));
            check("tbl_flag", 64'(s_sat[0]), 64'(tbl[t].flag));
`else
            check("tbl_value", 64'(s_eo[8:0]), 64'(tbl[t].want_wrap));
`endif
            drain(0, -1, 0, 1'b0);
        end

        for (int i = 0; i < N; i++) cur_x[i] = 3 * i + 1;
        cur_e = 7;
        send(0, 1'b1);
        begin
            int ax[N];
            int ae;
            ax = cur_x;
            ae = cur_e;
            for (int i = 0; i < N; i++) cur_x[i] = 200 - i;
            cur_e = 400;
            pack();
            cur_x = ax;
            cur_e = ae;
            drain(0, 1, 2, 1'b0);
            for (int i = 0; i < N; i++) cur_x[i] = 200 - i;
            cur_e = 400;
            @(posedge clk);
            #1;
            in_valid0 = 1'b0;
            drain(0, -1, 0, 1'b0);
        end

        for (int r = 0; r < 30; r++) begin
            for (int i = 0; i < N; i++) cur_x[i] = int'($urandom_range(0, 255));
            cur_e = int'($urandom_range(0, 511));
            send(r % 2, 1'b0);
            drain(r % 2, -1, 0, 1'b1);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
